// File: rtl/senha_checker_param_if.sv
// Keypad-side and lock-side signals of the password checker, bundled.
// master = keypad/test driver, slave = checker.
interface senha_checker_param_if #(
    parameter int CODE_W = 2,
    parameter int CNT_W  = 3
);
    logic              EM_SENHA;
    logic              EN;
    logic [CODE_W-1:0] COD;
    logic              S_INATI;
    logic              CERTO;
    logic              ERRO;
    logic              INATIVO;
    logic              BLOQ;
    logic [CNT_W-1:0]  DIG_CNT;

    modport master (
        output EM_SENHA, EN, COD,
        input  S_INATI, CERTO, ERRO, INATIVO, BLOQ, DIG_CNT
    );

    modport slave (
        input  EM_SENHA, EN, COD,
        output S_INATI, CERTO, ERRO, INATIVO, BLOQ, DIG_CNT
    );
endinterface

// File: rtl/senha_checker_param.sv
// Parametrised keypad password checker: DIGITS codes of CODE_W bits, inactivity
// timeout, early/late error reporting and lockout after MAX_ERR failed attempts.
module senha_checker_param #(
    parameter int                     DIGITS      = 4,
    parameter int                     CODE_W      = 2,
    parameter logic [DIGITS*CODE_W-1:0] SENHA     = 8'b00_10_10_00,
    parameter bit                     EARLY_ERR   = 1'b1,
    parameter int                     TIMEOUT_CYC = 16,
    parameter int                     MAX_ERR     = 3,
    parameter int                     LOCK_CYC    = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    senha_checker_param_if.slave  sc_if
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYC);
    localparam int LCK_W = $clog2(LOCK_CYC + 1);
    localparam int ERR_W = $clog2(MAX_ERR + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_OK    = 3'd2,
        ST_ER    = 3'd3,
        ST_IN    = 3'd4,
        ST_LOCK  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              mis_q, mis_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [LCK_W-1:0]  lck_q, lck_d;

    logic              s_inati_q, s_inati_d;
    logic              certo_q, certo_d;
    logic              erro_q, erro_d;
    logic              inativo_q, inativo_d;
    logic              bloq_q, bloq_d;
    logic [CNT_W-1:0]  dig_cnt_q, dig_cnt_d;

    // Digit 0 is the most significant slice of SENHA.
    logic [DIGITS-1:0][CODE_W-1:0] dig_tab;
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        assign dig_tab[g] = SENHA[(DIGITS-1-g)*CODE_W +: CODE_W];
    end

    logic              mis_now;
    logic [ERR_W-1:0]  err_inc;

    // Next-state logic; outputs are decoded from the next state so they are registered.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mis_d   = mis_q;
        tmr_d   = tmr_q;
        err_d   = err_q;
        lck_d   = lck_q;
        mis_now = (sc_if.COD != dig_tab[idx_q]);
        err_inc = (err_q == ERR_W'(MAX_ERR)) ? err_q : err_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (sc_if.EM_SENHA) begin
                    state_d = ST_ENTRY;
                    idx_d   = '0;
                    mis_d   = 1'b0;
                    tmr_d   = '0;
                end
            end
            ST_ENTRY: begin
                if (!sc_if.EM_SENHA) begin
                    // Abort wins over a simultaneous keypress; failures so far are kept.
                    state_d = ST_IDLE;
                end else if (sc_if.EN) begin
                    mis_d = mis_q | mis_now;
                    tmr_d = '0;
                    if (EARLY_ERR && mis_now) begin
                        state_d = ST_ER;
                    end else if (idx_q == IDX_W'(DIGITS-1)) begin
                        if (mis_q | mis_now) begin
                            state_d = ST_ER;
                        end else begin
                            state_d = ST_OK;
                            err_d   = '0;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (tmr_q == TMR_W'(TIMEOUT_CYC-1)) begin
                    state_d = ST_IN;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_OK, ST_IN: begin
                if (!sc_if.EM_SENHA) state_d = ST_IDLE;
            end
            ST_ER: begin
                err_d   = err_inc;
                lck_d   = '0;
                state_d = (err_inc == ERR_W'(MAX_ERR)) ? ST_LOCK : ST_IDLE;
            end
            ST_LOCK: begin
                // Inputs are deliberately ignored until the lockout expires.
                if (lck_q == LCK_W'(LOCK_CYC-1)) begin
                    state_d = ST_IDLE;
                    err_d   = '0;
                    lck_d   = '0;
                end else begin
                    lck_d = lck_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        s_inati_d = (state_d == ST_ENTRY);
        certo_d   = (state_d == ST_OK);
        erro_d    = (state_d == ST_ER);
        inativo_d = (state_d == ST_IN);
        bloq_d    = (state_d == ST_LOCK);
        dig_cnt_d = (state_d == ST_ENTRY) ? CNT_W'(idx_d) : '0;
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            mis_q     <= 1'b0;
            tmr_q     <= '0;
            err_q     <= '0;
            lck_q     <= '0;
            s_inati_q <= 1'b0;
            certo_q   <= 1'b0;
            erro_q    <= 1'b0;
            inativo_q <= 1'b0;
            bloq_q    <= 1'b0;
            dig_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            mis_q     <= mis_d;
            tmr_q     <= tmr_d;
            err_q     <= err_d;
            lck_q     <= lck_d;
            s_inati_q <= s_inati_d;
            certo_q   <= certo_d;
            erro_q    <= erro_d;
            inativo_q <= inativo_d;
            bloq_q    <= bloq_d;
            dig_cnt_q <= dig_cnt_d;
        end
    end

    assign sc_if.S_INATI = s_inati_q;
    assign sc_if.CERTO   = certo_q;
    assign sc_if.ERRO    = erro_q;
    assign sc_if.INATIVO = inativo_q;
    assign sc_if.BLOQ    = bloq_q;
    assign sc_if.DIG_CNT = dig_cnt_q;
endmodule

// File: tb/tb_senha_checker_param.sv
// Scoreboard bench: stimulus pushes each expected output change with the cycle
// it must appear in; a negedge monitor pops and compares on every output change.
module tb_senha_checker_param;
    logic clk;
    logic rst_n;
    int   cyc;

    senha_checker_param_if #(.CODE_W(2), .CNT_W(3)) if0 ();
    senha_checker_param_if #(.CODE_W(2), .CNT_W(3)) if1 ();

    senha_checker_param u_early (.clk(clk), .rst_n(rst_n), .sc_if(if0));
    senha_checker_param #(.EARLY_ERR(1'b0)) u_late (.clk(clk), .rst_n(rst_n), .sc_if(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // {S_INATI, CERTO, ERRO, INATIVO, BLOQ, DIG_CNT[2:0]}
    localparam logic [7:0] V_OK   = 8'b0100_0000;
    localparam logic [7:0] V_ER   = 8'b0010_0000;
    localparam logic [7:0] V_IN   = 8'b0001_0000;
    localparam logic [7:0] V_LOCK = 8'b0000_1000;
    function automatic logic [7:0] vs(int d);
        return 8'h80 | 8'(d);
    endfunction

    logic [7:0] obs [2];
    assign obs[0] = {if0.S_INATI, if0.CERTO, if0.ERRO, if0.INATIVO, if0.BLOQ, if0.DIG_CNT};
    assign obs[1] = {if1.S_INATI, if1.CERTO, if1.ERRO, if1.INATIVO, if1.BLOQ, if1.DIG_CNT};

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    int   n_vec = 0;
    int   n_bad = 0;
    bit   done = 1'b0;
    bit   drained = 1'b0;
    bit   seen [2];
    logic [7:0] prv [2];

    function automatic int qsize(int u);
        return (u == 0) ? q0.size() : q1.size();
    endfunction
    function automatic exp_t qfront(int u);
        return (u == 0) ? q0[0] : q1[0];
    endfunction
    task automatic qpop(int u);
        if (u == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask
    task automatic exp_push(int u, int d, logic [7:0] v);
        exp_t e;
        e.cyc = cyc + d;
        e.val = v;
        if (u == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic chk(int u, logic [7:0] o);
        exp_t e;
        for (int k = 0; k < 64; k++) begin
            if (qsize(u) == 0) break;
            e = qfront(u);
            if (e.cyc >= cyc) break;
            qpop(u);
            n_vec++;
            n_bad++;
            $display("FAIL missed u%0d: no change at cyc %0d, want %b, output is %b", u, e.cyc, e.val, o);
        end
        if (!seen[u] || o !== prv[u]) begin
            n_vec++;
            if (qsize(u) == 0) begin
                n_bad++;
                $display("FAIL unexpected u%0d: cyc %0d output %b, nothing expected", u, cyc, o);
            end else begin
                e = qfront(u);
                qpop(u);
                if (e.cyc != cyc || e.val !== o) begin
                    n_bad++;
                    $display("FAIL change u%0d: got %b at cyc %0d, want %b at cyc %0d", u, o, cyc, e.val, e.cyc);
                end
            end
        end
        seen[u] = 1'b1;
        prv[u]  = o;
    endtask

    // Monitor: compare every output change against the scoreboard.
    always @(negedge clk) begin
        chk(0, obs[0]);
        chk(1, obs[1]);
        if (done && !drained) begin
            drained = 1'b1;
            for (int k = 0; k < q0.size() + q1.size(); k++) begin
                n_vec++;
                n_bad++;
                $display("FAIL leftover: an expected change never appeared");
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_em(int u, logic v);
        if (u == 0) if0.EM_SENHA = v;
        else        if1.EM_SENHA = v;
    endtask

    task automatic key(int u, logic [1:0] c, int gap);
        if (u == 0) begin if0.EN = 1'b1; if0.COD = c; end
        else        begin if1.EN = 1'b1; if1.COD = c; end
        step(1);
        if (u == 0) if0.EN = 1'b0;
        else        if1.EN = 1'b0;
        step(gap - 1);
    endtask

    task automatic start(int u);
        set_em(u, 1'b1);
        exp_push(u, 1, vs(0));
        step(1);
    endtask

    task automatic stop(int u);
        set_em(u, 1'b0);
        exp_push(u, 1, 8'h00);
        step(1);
    endtask

    task automatic good(int u);
        start(u);
        exp_push(u, 1, vs(1)); key(u, 2'b00, 3);
        exp_push(u, 1, vs(2)); key(u, 2'b10, 3);
        exp_push(u, 1, vs(3)); key(u, 2'b10, 3);
        exp_push(u, 1, V_OK);  key(u, 2'b00, 3);
        step(4);
        stop(u);
    endtask

    // Early-error attempt 00,01 on the EARLY_ERR=1 unit.
    task automatic bad(bit lock);
        start(0);
        exp_push(0, 1, vs(1)); key(0, 2'b00, 3);
        exp_push(0, 1, V_ER);
        if (!lock) begin
            exp_push(0, 2, 8'h00);
            exp_push(0, 3, vs(0));
            key(0, 2'b01, 3);
            stop(0);
        end else begin
            exp_push(0, 2, V_LOCK);
            exp_push(0, 66, 8'h00);
            key(0, 2'b01, 1);
            if0.EM_SENHA = 1'b0;
            step(3);
            if0.EM_SENHA = 1'b1;
            key(0, 2'b00, 2);
            key(0, 2'b10, 5);
            if0.EM_SENHA = 1'b0;
            step(59);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        if0.EM_SENHA = 1'b0; if0.EN = 1'b0; if0.COD = 2'b00;
        if1.EM_SENHA = 1'b0; if1.EN = 1'b0; if1.COD = 2'b00;
        exp_push(0, 1, 8'h00);
        exp_push(1, 1, 8'h00);
        step(2);
        rst_n = 1'b1;

        good(0);
        bad(1'b0);

        // Timeout after exactly 16 idle cycles.
        start(0);
        exp_push(0, 1, vs(1));
        exp_push(0, 17, V_IN);
        key(0, 2'b00, 20);
        stop(0);

        // A keypress just before the limit restarts the timer.
        start(0);
        exp_push(0, 1, vs(1)); key(0, 2'b00, 15);
        exp_push(0, 1, vs(2)); key(0, 2'b10, 15);
        stop(0);

        bad(1'b0);
        good(0);
        bad(1'b0);
        good(0);

        bad(1'b0);
        bad(1'b0);
        bad(1'b1);
        good(0);
        bad(1'b0);

        // Late-error unit: 00,01,10,00 only fails after the last digit.
        start(1);
        exp_push(1, 1, vs(1)); key(1, 2'b00, 3);
        exp_push(1, 1, vs(2)); key(1, 2'b01, 3);
        exp_push(1, 1, vs(3)); key(1, 2'b10, 3);
        exp_push(1, 1, V_ER);
        exp_push(1, 2, 8'h00);
        exp_push(1, 3, vs(0));
        key(1, 2'b00, 3);
        stop(1);

        // Short reset pulse between clock edges mid-entry.
        start(0);
        exp_push(0, 1, vs(1)); key(0, 2'b00, 3);
        exp_push(0, 1, vs(2)); key(0, 2'b10, 3);
        exp_push(0, 1, vs(0));
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        step(1);
        stop(0);

        // Session drop together with the final correct keypress.
        start(0);
        exp_push(0, 1, vs(1)); key(0, 2'b00, 2);
        exp_push(0, 1, vs(2)); key(0, 2'b10, 2);
        exp_push(0, 1, vs(3)); key(0, 2'b10, 2);
        if0.EM_SENHA = 1'b0;
        exp_push(0, 1, 8'h00);
        key(0, 2'b00, 5);

        done = 1'b1;
        step(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/senha_checker_param.md
Name: senha_checker_param

Overview:
Parametrised successor of the team's keypad password FSM. Accepts a DIGITS-long sequence of CODE_W-bit codes while a session enable is held, and flags correct, error or inactivity. Adds an internal inactivity timer, a selectable early/late error mode, and lockout after repeated failures. Sits between the keypad encoder/debouncer (EN strobe and COD) and the lock/display controller.

Parameters:
DIGITS, 4, number of codes in the password (≥1).
CODE_W, 2, width of each code (≥1).
SENHA, 8'b00_10_10_00, password vector of DIGITS*CODE_W bits. Digit i is SENHA[(DIGITS-1-i)*CODE_W +: CODE_W], so digit 0 is the MSB slice.
EARLY_ERR, 1, 1 = go to error on the first wrong digit; 0 = error only after the last digit, so the failing position is not revealed.
TIMEOUT_CYC, 16, consecutive EN-free cycles in ENTRY before the inactivity flag (≥2).
MAX_ERR, 3, consecutive failed attempts that trigger lockout (≥1).
LOCK_CYC, 64, lockout duration in cycles (≥1).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
EM_SENHA  in  1  session enable; low aborts the session.
EN  in  1  one-cycle strobe: COD is valid.
COD  in  CODE_W  entered code.
S_INATI  out  1  entry in progress (state ENTRY).
CERTO  out  1  password accepted (state OK).
ERRO  out  1  one-cycle error pulse (state ER).
INATIVO  out  1  inactivity timeout (state IN).
BLOQ  out  1  lockout active (state LOCK).
DIG_CNT  out  $clog2(DIGITS+1)  digits accepted in the current attempt.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; idx, mismatch flag, timer, err_cnt and lock counter are 0; all outputs are 0.
- Outputs are Moore-decoded from registered state/idx. An input sampled at edge k is reflected after edge k.
- IDLE: EM_SENHA=1 → ENTRY, with idx=0, mismatch=0, timer=0.
- ENTRY, priority order:
  1. EM_SENHA=0 → IDLE (wins over a simultaneous EN). err_cnt is kept.
  2. EN=1: m = (COD != digit idx); mismatch |= m; timer=0.
     - If EARLY_ERR and m → ER.
     - Else if idx==DIGITS-1 → OK when (mismatch|m)==0, otherwise ER.
     - Else idx++ and stay in ENTRY.
  3. EN=0: timer++. At timer==TIMEOUT_CYC-1 → IN, so IN is entered after exactly TIMEOUT_CYC idle cycles.
- DIG_CNT = idx in ENTRY; 0 in every other state.
- OK: clears err_cnt on entry. Holds while EM_SENHA=1; EM_SENHA=0 → IDLE.
- ER: lasts exactly 1 cycle. err_cnt++ saturating at MAX_ERR. If the new err_cnt==MAX_ERR → LOCK, otherwise → IDLE. If EM_SENHA is still high, the retry starts via IDLE→ENTRY.
- IN: holds while EM_SENHA=1; EM_SENHA=0 → IDLE. Not counted as an error.
- LOCK: lock counter runs 0..LOCK_CYC-1 and ignores all inputs. At LOCK_CYC-1 → IDLE with err_cnt=0 and lock counter=0.
- EN outside ENTRY is ignored.
- Illegal state encodings → IDLE.
- Counter widths: timer is $clog2(TIMEOUT_CYC); lock counter is $clog2(LOCK_CYC+1); err_cnt is $clog2(MAX_ERR+1). No wrap-around beyond terminal values.
- rst_n asserted mid-session forces IDLE immediately, regardless of clk.

Test Plan:
- Defaults; EM_SENHA=1; EN pulses with COD 00,10,10,00, each 3 cycles apart → S_INATI=1 and DIG_CNT steps 0..3; CERTO=1 one cycle after the 4th EN; CERTO holds until EM_SENHA=0, then all outputs are 0.
- EARLY_ERR=1; codes 00,01 → ERRO pulses exactly one cycle after the 2nd EN; then S_INATI=1 again with DIG_CNT=0. Same stimulus with EARLY_ERR=0 → no ERRO until the 4th EN, then one ERRO pulse.
- Enter 00 then idle 16 cycles with EM_SENHA=1 → INATIVO rises on cycle 16 after the last EN and holds; EM_SENHA=0 → IDLE. An EN on cycle 15 instead resets the timer, and INATIVO stays 0.
- Three consecutive wrong attempts → third ERRO pulse, then BLOQ=1 for exactly 64 cycles with EN/EM_SENHA ignored. Then a correct sequence gives CERTO. A fourth attempt after that does not lock, because err_cnt was cleared.
- Two wrong attempts, then a correct one, then a wrong one → no lockout (err_cnt cleared by OK).
- rst_n pulsed low mid-entry (DIG_CNT=2) → all outputs 0 asynchronously. EM_SENHA dropped mid-entry with a simultaneous EN → IDLE, no ERRO/CERTO.
